// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/response bus between fetch stage and memory
interface if_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC owner and IF/ID filler with one outstanding fetch and a one-entry stall hold buffer
module if_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  if_stage_if.master      imem,
  input  logic            stall_if_i,
  input  logic            flush_ifid_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i,
  output logic            ifid_valid_o,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_pc_plus4_o,
  output logic [31:0]     ifid_instr_o
);
  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_e;
  state_e          state_q;
  logic [XLEN-1:0] pc_q, req_pc_q, hold_pc_q, target;
  logic [31:0]     hold_instr_q;
  logic            hold_q, grant, deliver, kill_ifid;
  assign target    = {ex_redirect_pc_i[XLEN-1:2], 2'b00};
  assign imem.req  = rst_n && state_q == IDLE && !hold_q && !ex_redirect_i;
  assign imem.addr = pc_q;
  assign grant     = imem.req && imem.gnt;
  assign deliver   = state_q == WAIT && imem.rvalid && !ex_redirect_i;
  assign kill_ifid = flush_ifid_i || ex_redirect_i;
  // PC and request FSM: a redirect while a request is in flight turns its response into a discard
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (ex_redirect_i) pc_q <= target;
      else if (grant) begin
        pc_q     <= pc_q + XLEN'(4);
        req_pc_q <= pc_q;
      end
      state_q <= state_q == IDLE ? (grant ? WAIT : IDLE) :
                 imem.rvalid ? IDLE :
                 (state_q == WAIT && ex_redirect_i) ? KILL : state_q;
    end
  // IF/ID register and hold buffer: flush beats stall, buffered word beats a fresh response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q          <= 1'b0;
      hold_pc_q       <= '0;
      hold_instr_q    <= NOP_INSTR;
      ifid_valid_o    <= 1'b0;
      ifid_pc_o       <= '0;
      ifid_pc_plus4_o <= '0;
      ifid_instr_o    <= NOP_INSTR;
    end else if (kill_ifid) begin
      hold_q       <= 1'b0;
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end else if (stall_if_i) begin
      if (deliver) begin
        hold_q       <= 1'b1;
        hold_pc_q    <= req_pc_q;
        hold_instr_q <= imem.rdata;
      end
    end else if (hold_q) begin
      hold_q          <= 1'b0;
      ifid_valid_o    <= 1'b1;
      ifid_pc_o       <= hold_pc_q;
      ifid_pc_plus4_o <= hold_pc_q + XLEN'(4);
      ifid_instr_o    <= hold_instr_q;
    end else if (deliver) begin
      ifid_valid_o    <= 1'b1;
      ifid_pc_o       <= req_pc_q;
      ifid_pc_plus4_o <= req_pc_q + XLEN'(4);
      ifid_instr_o    <= imem.rdata;
    end else begin
      ifid_valid_o <= 1'b0;
      ifid_instr_o <= NOP_INSTR;
    end
endmodule
